// File: rtl/calc_core_param_if.sv
// calc_core_param_if -- keypad-to-calculator link.
//   newkey/keycode   : one-cycle key event from the keypad scanner
//   value/sign       : sign-magnitude display register
//   ovw              : sticky overflow flag
//   busy             : multiplier running
//   key_drop         : one-cycle pulse for a key rejected while busy
//   mem_nz           : memory register non-zero (0 when memory is not built)
interface calc_core_param_if #(
  parameter int WIDTH = 16
);
  logic             newkey;
  logic [4:0]       keycode;
  logic [WIDTH-1:0] value;
  logic             sign;
  logic             ovw;
  logic             busy;
  logic             key_drop;
  logic             mem_nz;

  modport master (
    output newkey, keycode,
    input  value, sign, ovw, busy, key_drop, mem_nz
  );

  modport slave (
    input  newkey, keycode,
    output value, sign, ovw, busy, key_drop, mem_nz
  );
endinterface

// File: rtl/calc_core_param.sv
// calc_core_param -- parametrised keypad calculator core.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   kb    : calc_core_param_if slave (key events in, display/status out)
// Keeps a WIDTH-bit sign-magnitude display D and accumulator A, a pending
// operator and a 'fresh' entry flag. Add/sub resolve in one cycle; mul runs
// a WIDTH-cycle shift-add with busy asserted and other keys dropped.
// Optional memory register (M+, MR, MC) is built when CALC_MEMORY_EN is
// defined; otherwise those keycodes are ignored and mem_nz is tied low.
module calc_core_param #(
  parameter int WIDTH = 16
) (
  input logic              clock,
  input logic              reset,
  calc_core_param_if.slave kb
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [4:0] K_ADD = 5'h10;
  localparam logic [4:0] K_SUB = 5'h11;
  localparam logic [4:0] K_MUL = 5'h12;
  localparam logic [4:0] K_EQ  = 5'h13;
  localparam logic [4:0] K_BS  = 5'h14;
  localparam logic [4:0] K_CE  = 5'h15;
  localparam logic [4:0] K_CA  = 5'h16;
  localparam logic [4:0] K_TOG = 5'h17;
`ifdef CALC_MEMORY_EN
  localparam logic [4:0] K_MPLUS = 5'h18;
  localparam logic [4:0] K_MR    = 5'h19;
  localparam logic [4:0] K_MC    = 5'h1A;
`endif

  typedef enum logic [1:0] {ST_ENTRY, ST_MUL, ST_RESULT} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_t;

  state_t             state_q, state_d;
  op_t                op_q, op_d, key_op;
  logic [WIDTH-1:0]   d_mag_q, d_mag_d, a_mag_q, a_mag_d;
  logic               d_sign_q, d_sign_d, a_sign_q, a_sign_d;
  logic               fresh_q, fresh_d, ovw_q, ovw_d;
  logic               busy_q, busy_d, key_drop_q, key_drop_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, mcand_q, mcand_d, prod_nxt;
  logic [WIDTH-1:0]   mplier_q, mplier_d, mul_mag;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               mul_sign_q, mul_sign_d, to_acc_q, to_acc_d;
  logic               start_mul, is_ca;
  logic [WIDTH+1:0]   ev;
`ifdef CALC_MEMORY_EN
  logic [WIDTH-1:0]   mem_mag_q, mem_mag_d;
  logic               mem_sign_q, mem_sign_d, mem_nz_q, mem_nz_d;
  logic [WIDTH+1:0]   mem_ev;
`endif

  // Signed add/sub on WIDTH+2 bits, returned as {overflow, sign, magnitude}.
  // A zero magnitude (including an overflowed one) always reports +0.
  function automatic logic [WIDTH+1:0] addsub(
    input logic sa, input logic [WIDTH-1:0] ma,
    input logic sb, input logic [WIDTH-1:0] mb,
    input logic sub
  );
    logic signed [WIDTH+1:0] x, y, r, r_abs;
    logic [WIDTH-1:0]        mag;
    x = $signed({2'b00, ma});
    if (sa) x = -x;
    y = $signed({2'b00, mb});
    if (sb ^ sub) y = -y;
    r     = x + y;
    r_abs = r[WIDTH+1] ? -r : r;
    mag   = r_abs[WIDTH-1:0];
    return {|r_abs[WIDTH+1:WIDTH], r[WIDTH+1] && (mag != '0), mag};
  endfunction

  always_comb begin
    unique case (kb.keycode)
      K_SUB:   key_op = OP_SUB;
      K_MUL:   key_op = OP_MUL;
      default: key_op = OP_ADD;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    d_mag_d    = d_mag_q;
    d_sign_d   = d_sign_q;
    a_mag_d    = a_mag_q;
    a_sign_d   = a_sign_q;
    fresh_d    = fresh_q;
    ovw_d      = ovw_q;
    busy_d     = busy_q;
    key_drop_d = 1'b0;
    prod_d     = prod_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    mul_sign_d = mul_sign_q;
    to_acc_d   = to_acc_q;
    start_mul  = 1'b0;
    is_ca      = kb.newkey && (kb.keycode == K_CA);
    ev         = addsub(a_sign_q, a_mag_q, d_sign_q, d_mag_q, op_q == OP_SUB);
    prod_nxt   = prod_q + (mplier_q[0] ? mcand_q : '0);
    mul_mag    = prod_nxt[WIDTH-1:0];
`ifdef CALC_MEMORY_EN
    mem_mag_d  = mem_mag_q;
    mem_sign_d = mem_sign_q;
    mem_ev     = addsub(mem_sign_q, mem_mag_q, d_sign_q, d_mag_q, 1'b0);
`endif

    unique case (state_q)
      ST_MUL: begin
        if (kb.newkey) key_drop_d = 1'b1;
        prod_d   = prod_nxt;
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        // Last iteration writes the result on the same edge busy drops.
        if (cnt_q == CW'(WIDTH - 1)) begin
          d_mag_d  = mul_mag;
          d_sign_d = mul_sign_q && (mul_mag != '0);
          if (to_acc_q) begin
            a_mag_d  = mul_mag;
            a_sign_d = mul_sign_q && (mul_mag != '0);
          end
          ovw_d   = ovw_q | (|prod_nxt[2*WIDTH-1:WIDTH]);
          busy_d  = 1'b0;
          state_d = ST_RESULT;
        end
      end
      default: begin
        if (state_q == ST_RESULT) state_d = ST_ENTRY;
        if (kb.newkey) begin
          if (!kb.keycode[4]) begin
            if (fresh_q) begin
              d_mag_d  = WIDTH'(kb.keycode[3:0]);
              d_sign_d = 1'b0;
              fresh_d  = 1'b0;
              ovw_d    = 1'b0;
            end else if (d_mag_q[WIDTH-1:WIDTH-4] == 4'h0) begin
              d_mag_d = {d_mag_q[WIDTH-5:0], kb.keycode[3:0]};
            end
          end else begin
            case (kb.keycode)
              K_ADD, K_SUB, K_MUL: begin
                if (op_q != OP_NONE && !fresh_q) begin
                  if (op_q == OP_MUL) begin
                    start_mul = 1'b1;
                    to_acc_d  = 1'b1;
                  end else begin
                    d_mag_d  = ev[WIDTH-1:0];
                    d_sign_d = ev[WIDTH];
                    a_mag_d  = ev[WIDTH-1:0];
                    a_sign_d = ev[WIDTH];
                    ovw_d    = ovw_q | ev[WIDTH+1];
                  end
                end else begin
                  a_mag_d  = d_mag_q;
                  a_sign_d = d_sign_q;
                end
                op_d    = key_op;
                fresh_d = 1'b1;
              end
              K_EQ: begin
                if (op_q == OP_MUL) begin
                  start_mul = 1'b1;
                  to_acc_d  = 1'b0;
                end else if (op_q != OP_NONE) begin
                  d_mag_d  = ev[WIDTH-1:0];
                  d_sign_d = ev[WIDTH];
                  ovw_d    = ovw_q | ev[WIDTH+1];
                end
                op_d    = OP_NONE;
                fresh_d = 1'b1;
              end
              K_BS: begin
                if (!fresh_q) begin
                  d_mag_d = d_mag_q >> 4;
                  if (d_mag_q[WIDTH-1:4] == '0) d_sign_d = 1'b0;
                end
              end
              K_CE: begin
                d_mag_d  = '0;
                d_sign_d = 1'b0;
                ovw_d    = 1'b0;
                fresh_d  = 1'b0;
              end
              K_TOG: begin
                if (d_mag_q != '0) d_sign_d = ~d_sign_q;
              end
`ifdef CALC_MEMORY_EN
              K_MPLUS: begin
                mem_mag_d  = mem_ev[WIDTH-1:0];
                mem_sign_d = mem_ev[WIDTH];
                ovw_d      = ovw_q | mem_ev[WIDTH+1];
              end
              K_MR: begin
                d_mag_d  = mem_mag_q;
                d_sign_d = mem_sign_q;
                fresh_d  = 1'b0;
              end
              K_MC: begin
                mem_mag_d  = '0;
                mem_sign_d = 1'b0;
              end
`endif
              default: ;
            endcase
          end
        end
      end
    endcase

    if (start_mul) begin
      prod_d     = '0;
      mcand_d    = {{WIDTH{1'b0}}, a_mag_q};
      mplier_d   = d_mag_q;
      cnt_d      = '0;
      mul_sign_d = a_sign_q ^ d_sign_q;
      busy_d     = 1'b1;
      state_d    = ST_MUL;
    end

    // CA wins in every state, including an in-flight multiply; memory survives.
    if (is_ca) begin
      state_d    = ST_ENTRY;
      op_d       = OP_NONE;
      d_mag_d    = '0;
      d_sign_d   = 1'b0;
      a_mag_d    = '0;
      a_sign_d   = 1'b0;
      fresh_d    = 1'b0;
      ovw_d      = 1'b0;
      busy_d     = 1'b0;
      key_drop_d = 1'b0;
    end
`ifdef CALC_MEMORY_EN
    mem_nz_d = (mem_mag_d != '0);
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_ENTRY;
      op_q       <= OP_NONE;
      d_mag_q    <= '0;
      d_sign_q   <= 1'b0;
      a_mag_q    <= '0;
      a_sign_q   <= 1'b0;
      fresh_q    <= 1'b0;
      ovw_q      <= 1'b0;
      busy_q     <= 1'b0;
      key_drop_q <= 1'b0;
      prod_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      mul_sign_q <= 1'b0;
      to_acc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      d_mag_q    <= d_mag_d;
      d_sign_q   <= d_sign_d;
      a_mag_q    <= a_mag_d;
      a_sign_q   <= a_sign_d;
      fresh_q    <= fresh_d;
      ovw_q      <= ovw_d;
      busy_q     <= busy_d;
      key_drop_q <= key_drop_d;
      prod_q     <= prod_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      mul_sign_q <= mul_sign_d;
      to_acc_q   <= to_acc_d;
    end
  end

`ifdef CALC_MEMORY_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_mag_q  <= '0;
      mem_sign_q <= 1'b0;
      mem_nz_q   <= 1'b0;
    end else begin
      mem_mag_q  <= mem_mag_d;
      mem_sign_q <= mem_sign_d;
      mem_nz_q   <= mem_nz_d;
    end
  end
  assign kb.mem_nz = mem_nz_q;
`else
  assign kb.mem_nz = 1'b0;
`endif

  assign kb.value    = d_mag_q;
  assign kb.sign     = d_sign_q;
  assign kb.ovw      = ovw_q;
  assign kb.busy     = busy_q;
  assign kb.key_drop = key_drop_q;

endmodule

// File: tb/tb_calc_core_param.sv
// Directed bench for calc_core_param at WIDTH=16 (memory checks follow
// CALC_MEMORY_EN when it is defined for the build).
module tb_calc_core_param;
  localparam int WIDTH = 16;

  localparam logic [4:0] K_ADD = 5'h10, K_SUB = 5'h11, K_MUL = 5'h12, K_EQ = 5'h13;
  localparam logic [4:0] K_BS = 5'h14, K_CE = 5'h15, K_CA = 5'h16, K_TOG = 5'h17;
  localparam logic [4:0] K_MPLUS = 5'h18, K_MR = 5'h19, K_MC = 5'h1A, K_IGN = 5'h1C;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   busy_cycles;

  calc_core_param_if #(.WIDTH(WIDTH)) bus ();

  calc_core_param #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .kb    (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Key held for one cycle; returns #1 after the sampling edge.
  task automatic press(input logic [4:0] k);
    @(posedge clock); #1;
    bus.newkey  = 1'b1;
    bus.keycode = k;
    @(posedge clock); #1;
    bus.newkey  = 1'b0;
  endtask

  // Counts post-edge samples with busy high, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(posedge clock); #1;
    end
    check("busy_timeout", {31'b0, bus.busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.newkey  = 1'b0;
    bus.keycode = 5'h00;
    #12;
    check("rst_value", {16'b0, bus.value}, 32'h0);
    check("rst_flags", {26'b0, bus.sign, bus.ovw, bus.busy, bus.key_drop, bus.mem_nz, 1'b0}, 32'h0);
    #11 reset = 1'b1;

    // 12 + 34 = 46, then 46 - 50 = -0A (hex entry)
    press(5'h1); press(5'h2);
    check("digits_12", {16'b0, bus.value}, 32'h12);
    press(K_ADD); press(5'h3); press(5'h4); press(K_EQ);
    check("add_val", {16'b0, bus.value}, 32'h46);
    check("add_sign_ovw", {30'b0, bus.sign, bus.ovw}, 32'h0);
    press(K_SUB); press(5'h5); press(5'h0); press(K_EQ);
    check("sub_val", {16'b0, bus.value}, 32'h0A);
    check("sub_sign", {31'b0, bus.sign}, 32'h1);

    // FFFF + 1 overflows to +0 with ovw; fresh digit clears ovw
    press(K_CA);
    press(5'hF); press(5'hF); press(5'hF); press(5'hF);
    check("ffff", {16'b0, bus.value}, 32'hFFFF);
    press(K_ADD); press(5'h1); press(K_EQ);
    check("ovf_val", {16'b0, bus.value}, 32'h0);
    check("ovf_flags", {30'b0, bus.sign, bus.ovw}, 32'h1);
    press(5'h7);
    check("fresh_digit", {15'b0, bus.ovw, bus.value}, 32'h0007);
    press(5'hF); press(5'hF); press(5'hF); press(5'h1);
    check("digit_full_discard", {16'b0, bus.value}, 32'h7FFF);

    // 100 * 100 = 0x10000: busy for 16 cycles, low word 0, ovw set
    press(K_CA);
    press(5'h1); press(5'h0); press(5'h0); press(K_MUL);
    check("mul_key_not_busy", {31'b0, bus.busy}, 32'h0);
    press(5'h1); press(5'h0); press(5'h0); press(K_EQ);
    wait_idle(busy_cycles);
    check("mul_busy_len", busy_cycles, 32'd16);
    check("mul_ovf_val", {16'b0, bus.value}, 32'h0);
    check("mul_ovf_flags", {30'b0, bus.sign, bus.ovw}, 32'h1);
    press(5'h3); press(K_TOG);
    check("toggle", {14'b0, bus.sign, bus.ovw, bus.value}, 32'h20003);
    press(K_MUL); press(5'h4); press(K_EQ);
    wait_idle(busy_cycles);
    check("mul_neg", {15'b0, bus.sign, bus.value}, 32'h1000C);

    // Key during busy is dropped; CA during busy aborts
    press(K_CA);
    press(5'h2); press(K_MUL); press(5'h3); press(K_EQ);
    press(5'h9);
    check("drop_pulse", {31'b0, bus.key_drop}, 32'h1);
    check("drop_value", {16'b0, bus.value}, 32'h3);
    @(posedge clock); #1;
    check("drop_one_cycle", {31'b0, bus.key_drop}, 32'h0);
    wait_idle(busy_cycles);
    check("mul_2x3", {15'b0, bus.sign, bus.value}, 32'h6);
    press(5'h2); press(K_MUL); press(5'h3); press(K_EQ);
    check("busy_before_ca", {31'b0, bus.busy}, 32'h1);
    press(K_CA);
    check("ca_abort", {14'b0, bus.busy, bus.key_drop, bus.value}, 32'h0);

    // -5 + 5 must give +0; toggle on zero stays positive
    press(5'h5); press(K_TOG); press(K_ADD); press(5'h5); press(K_EQ);
    check("no_neg_zero", {15'b0, bus.sign, bus.value}, 32'h0);
    press(K_TOG);
    check("toggle_zero", {31'b0, bus.sign}, 32'h0);

    // Backspace, CE, ignored key
    press(K_CA);
    press(5'h1); press(5'h2); press(5'h3); press(K_BS);
    check("bs", {16'b0, bus.value}, 32'h12);
    press(K_IGN);
    check("ignored_key", {16'b0, bus.value}, 32'h12);
    press(K_CE);
    check("ce", {15'b0, bus.sign, bus.value}, 32'h0);

    // FFFF + F = 0x1000E -> 000E with ovw, then async reset mid-cycle
    press(K_CA);
    press(5'hF); press(5'hF); press(5'hF); press(5'hF);
    press(K_ADD); press(5'hF); press(K_EQ);
    check("ovf_low_bits", {15'b0, bus.ovw, bus.value}, 32'h1000E);
    #2 reset = 1'b0;
    #1;
    check("async_rst", {11'b0, bus.sign, bus.ovw, bus.busy, bus.key_drop, bus.mem_nz, bus.value}, 32'h0);
    #3 reset = 1'b1;

    // Memory keys
    press(5'h5); press(K_MPLUS);
`ifdef CALC_MEMORY_EN
    check("mem_nz_set", {31'b0, bus.mem_nz}, 32'h1);
`else
    check("mem_nz_off", {31'b0, bus.mem_nz}, 32'h0);
`endif
    press(K_MPLUS); press(K_CA); press(5'h3); press(K_MR);
`ifdef CALC_MEMORY_EN
    check("mr_value", {16'b0, bus.value}, 32'hA);
    check("mr_mem_nz", {31'b0, bus.mem_nz}, 32'h1);
`else
    check("mr_ignored", {16'b0, bus.value}, 32'h3);
    check("mr_mem_nz_off", {31'b0, bus.mem_nz}, 32'h0);
`endif
    press(K_MC);
    check("mc_mem_nz", {31'b0, bus.mem_nz}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
